// File: rtl/core_ctrl_pkg.sv
// Shared control package: sequencer states, RV32I opcodes and the
// default PC geometry shared by the sequencer and the decoder.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } seq_state_t;

  localparam int SEQ_ADDR_WIDTH = 7;
  localparam int SEQ_RESET_PC   = 0;
  localparam int SEQ_LAST_PC    = 73;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/pc_unit.sv
// PC register with next-PC latch and LAST_PC wrap.
// Ports: clock/reset, latch (EXEC), take_target, target_pc, update (WB), pc.
module pc_unit
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int RESET_PC   = SEQ_RESET_PC,
  parameter int LAST_PC    = SEQ_LAST_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  latch,
  input  logic                  take_target,
  input  logic [ADDR_WIDTH-1:0] target_pc,
  input  logic                  update,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] C_RST  = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(LAST_PC);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [ADDR_WIDTH-1:0] w_seq;
  logic [ADDR_WIDTH-1:0] w_sel;

  // Sequential successor wraps modulo 2^ADDR_WIDTH.
  assign w_seq = r_pc + ADDR_WIDTH'(1);
  assign w_sel = take_target ? target_pc : w_seq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc   <= C_RST;
      r_next <= C_RST;
    end else begin
      if (latch)
        r_next <= w_sel;
      if (update)
        r_pc <= (r_next > C_LAST) ? C_RST : r_next;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, IR load, exec, mem, writeback.
// Ports: clock/reset, run/step, decoder class flags, branch_taken,
// target_pc, dmem_ack; strobes imem_re/ir_load/rf_we/dmem_req/dmem_we,
// pc/imem_addr, busy, halted, illegal, instret.
// Macro SEQ_INSTRET_EN enables the retired-instruction counter.
module instr_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int RESET_PC   = SEQ_RESET_PC,
  parameter int LAST_PC    = SEQ_LAST_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  is_alu_reg,
  input  logic                  is_alu_imm,
  input  logic                  is_branch,
  input  logic                  is_jalr,
  input  logic                  is_jal,
  input  logic                  is_auipc,
  input  logic                  is_lui,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_system,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] target_pc,
  input  logic                  dmem_ack,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_re,
  output logic                  ir_load,
  output logic                  rf_we,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [31:0]           instret
);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic w_any_flag;
  logic w_take;
  logic w_writes_rf;
  logic w_halt_now;
  logic r_halted;
  logic r_illegal;
  logic r_is_store;
  logic r_wb_en;
  logic [ADDR_WIDTH-1:0] w_pc;

  assign w_any_flag = |{is_alu_reg, is_alu_imm, is_branch, is_jalr,
                        is_jal, is_auipc, is_lui, is_load, is_store,
                        is_system};

  assign w_take = is_jal | is_jalr | (is_branch & branch_taken);

  assign w_writes_rf = is_alu_reg | is_alu_imm | is_lui | is_auipc |
                       is_jal | is_jalr | is_load;

  assign w_halt_now = (r_state == DECODE) &&
                      (is_system || !w_any_flag);

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (run || step) w_next_state = FETCH;
      FETCH:   w_next_state = WAIT;
      WAIT:    w_next_state = DECODE;
      DECODE:  w_next_state = w_halt_now ? HALT : EXEC;
      EXEC:    w_next_state = (is_load || is_store) ? MEM : WB;
      MEM:     if (dmem_ack) w_next_state = WB;
      WB:      w_next_state = run ? FETCH : IDLE;
      HALT:    w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
  end

  // Class-dependent strobe qualifiers are captured in EXEC so the
  // MEM/WB strobes depend on registered state only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      r_is_store <= 1'b0;
      r_wb_en    <= 1'b0;
    end else begin
      if (w_halt_now) begin
        r_halted  <= 1'b1;
        r_illegal <= !w_any_flag;
      end
      if (r_state == EXEC) begin
        r_is_store <= is_store;
        r_wb_en    <= w_writes_rf;
      end
    end
  end

  pc_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC),
    .LAST_PC    (LAST_PC)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .latch       (r_state == EXEC),
    .take_target (w_take),
    .target_pc   (target_pc),
    .update      (r_state == WB),
    .pc          (w_pc)
  );

`ifdef SEQ_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clock) begin
    if (reset)
      r_instret <= 32'd0;
    else if (r_state == WB)
      r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = 32'd0;
`endif

  assign pc        = w_pc;
  assign imem_addr = w_pc;
  assign imem_re   = (r_state == FETCH);
  assign ir_load   = (r_state == WAIT);
  assign dmem_req  = (r_state == MEM);
  assign dmem_we   = (r_state == MEM) && r_is_store;
  assign rf_we     = (r_state == WB) && r_wb_en;
  assign busy      = (r_state != IDLE) && (r_state != HALT);
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// Acts as decoder/dmem model via hand-set class flags and ack timing.
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [9:0] flags = '0;
  logic       branch_taken = 1'b0;
  logic [6:0] target_pc = '0;
  logic       dmem_ack = 1'b0;
  logic [6:0] imem_addr;
  logic       imem_re;
  logic       ir_load;
  logic       rf_we;
  logic       dmem_req;
  logic       dmem_we;
  logic [6:0] pc;
  logic       busy;
  logic       halted;
  logic       illegal;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [9:0] C_ADDI   = 10'h002;
  localparam logic [9:0] C_BRANCH = 10'h004;
  localparam logic [9:0] C_JAL    = 10'h010;
  localparam logic [9:0] C_LOAD   = 10'h080;
  localparam logic [9:0] C_STORE  = 10'h100;
  localparam logic [9:0] C_SYSTEM = 10'h200;

`ifdef SEQ_INSTRET_EN
  localparam int EXP_RET3 = 3;
`else
  localparam int EXP_RET3 = 0;
`endif

  instr_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .is_alu_reg   (flags[0]),
    .is_alu_imm   (flags[1]),
    .is_branch    (flags[2]),
    .is_jalr      (flags[3]),
    .is_jal       (flags[4]),
    .is_auipc     (flags[5]),
    .is_lui       (flags[6]),
    .is_load      (flags[7]),
    .is_store     (flags[8]),
    .is_system    (flags[9]),
    .branch_taken (branch_taken),
    .target_pc    (target_pc),
    .dmem_ack     (dmem_ack),
    .imem_addr    (imem_addr),
    .imem_re      (imem_re),
    .ir_load      (ir_load),
    .rf_we        (rf_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Pulse step once and watch the instruction until the FSM is idle.
  task automatic run_one(input int ack_delay, output int cyc,
                         output int rfw, output int rfw_c,
                         output int req, output bit we,
                         output int ack_c, output bit done);
    cyc = 0; rfw = 0; rfw_c = 0; req = 0; we = 0; ack_c = 0; done = 0;
    @(negedge clock);
    step = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      step = 1'b0;
      dmem_ack = 1'b0;
      if (!busy) begin
        done = 1;
        break;
      end
      cyc++;
      if (rf_we) begin
        rfw++;
        rfw_c = c;
      end
      if (dmem_req) begin
        req++;
        if (dmem_we) we = 1;
        if (req == ack_delay + 1) begin
          dmem_ack = 1'b1;
          ack_c = c;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (pc !== 7'd0) begin
      n_bad++; $display("FAIL reset_pc got %0d want 0", pc);
    end
    n_cmp++;
    if ({busy, halted, illegal} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000",
                        {busy, halted, illegal});
    end
    n_cmp++;
    if ({imem_re, ir_load, rf_we, dmem_req, dmem_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes got %b want 00000",
                        {imem_re, ir_load, rf_we, dmem_req, dmem_we});
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_bad++; $display("FAIL reset_instret got %0d want 0", instret);
    end
  endtask

  task automatic test_run_addi();
    logic [6:0] ire, irl, rfw;
    logic [6:0] pcs [7];
    bit done;
    flags = C_ADDI;
    run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      ire[c] = imem_re;
      irl[c] = ir_load;
      rfw[c] = rf_we;
      pcs[c] = pc;
    end
    run = 1'b0;
    n_cmp++;
    if (ire[6:1] !== 6'b100001) begin
      n_bad++; $display("FAIL run_imem_re got %b want 100001", ire[6:1]);
    end
    n_cmp++;
    if (irl[6:1] !== 6'b000010) begin
      n_bad++; $display("FAIL run_ir_load got %b want 000010", irl[6:1]);
    end
    n_cmp++;
    if (rfw[6:1] !== 6'b010000) begin
      n_bad++; $display("FAIL run_rf_we got %b want 010000", rfw[6:1]);
    end
    n_cmp++;
    if (pcs[5] !== 7'd0 || pcs[6] !== 7'd1) begin
      n_bad++; $display("FAIL run_pc got %0d,%0d want 0,1", pcs[5], pcs[6]);
    end
    done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    n_cmp++;
    if (!done || pc !== 7'd2) begin
      n_bad++; $display("FAIL run_fall got done=%0d pc=%0d want 1,2",
                        done, pc);
    end
  endtask

  task automatic test_step();
    int cyc, rfw, rfw_c, req, ack_c;
    bit we, done;
    flags = C_ADDI;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (!done || cyc !== 5 || rfw !== 1) begin
      n_bad++; $display("FAIL step_one got done=%0d cyc=%0d rfw=%0d want 1,5,1",
                        done, cyc, rfw);
    end
    n_cmp++;
    if (pc !== 7'd3 || busy !== 1'b0) begin
      n_bad++; $display("FAIL step_pc got pc=%0d busy=%0d want 3,0", pc, busy);
    end
    n_cmp++;
    if (instret !== 32'(EXP_RET3)) begin
      n_bad++; $display("FAIL instret3 got %0d want %0d", instret, EXP_RET3);
    end
  endtask

  task automatic test_jumps();
    int cyc, rfw, rfw_c, req, ack_c;
    bit we, done;
    flags = C_JAL; target_pc = 7'd10;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (pc !== 7'd10 || rfw !== 1) begin
      n_bad++; $display("FAIL jal got pc=%0d rfw=%0d want 10,1", pc, rfw);
    end
    flags = C_BRANCH; target_pc = 7'd20; branch_taken = 1'b0;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (pc !== 7'd11 || rfw !== 0) begin
      n_bad++; $display("FAIL beq_nt got pc=%0d rfw=%0d want 11,0", pc, rfw);
    end
    target_pc = 7'd5; branch_taken = 1'b1;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    branch_taken = 1'b0;
    n_cmp++;
    if (pc !== 7'd5 || rfw !== 0) begin
      n_bad++; $display("FAIL bne_t got pc=%0d rfw=%0d want 5,0", pc, rfw);
    end
  endtask

  task automatic test_wrap();
    int cyc, rfw, rfw_c, req, ack_c;
    bit we, done;
    flags = C_JAL; target_pc = 7'd73;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (pc !== 7'd73) begin
      n_bad++; $display("FAIL jal73 got pc=%0d want 73", pc);
    end
    flags = C_ADDI;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (pc !== 7'd0) begin
      n_bad++; $display("FAIL wrap73 got pc=%0d want 0", pc);
    end
    flags = C_JAL; target_pc = 7'd100;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (pc !== 7'd0) begin
      n_bad++; $display("FAIL wrap100 got pc=%0d want 0", pc);
    end
  endtask

  task automatic test_mem();
    int cyc, rfw, rfw_c, req, ack_c;
    bit we, done;
    flags = C_LOAD;
    run_one(3, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (req !== 4 || we !== 1'b0) begin
      n_bad++; $display("FAIL lw_req got req=%0d we=%0d want 4,0", req, we);
    end
    n_cmp++;
    if (rfw !== 1 || rfw_c !== ack_c + 1) begin
      n_bad++; $display("FAIL lw_wb got rfw=%0d at %0d want 1 at %0d",
                        rfw, rfw_c, ack_c + 1);
    end
    n_cmp++;
    if (!done || cyc !== 9 || pc !== 7'd1) begin
      n_bad++; $display("FAIL lw_lat got cyc=%0d pc=%0d want 9,1", cyc, pc);
    end
    flags = C_STORE;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (req !== 1 || we !== 1'b1 || rfw !== 0) begin
      n_bad++; $display("FAIL sw got req=%0d we=%0d rfw=%0d want 1,1,0",
                        req, we, rfw);
    end
    n_cmp++;
    if (!done || cyc !== 6 || pc !== 7'd2) begin
      n_bad++; $display("FAIL sw_lat got cyc=%0d pc=%0d want 6,2", cyc, pc);
    end
  endtask

  task automatic test_reset_in_mem();
    bit seen;
    logic [6:0] pc_before;
    flags = C_LOAD;
    seen = 0;
    @(negedge clock);
    step = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      step = 1'b0;
      if (dmem_req) begin
        seen = 1;
        break;
      end
    end
    @(negedge clock);
    pc_before = pc;
    n_cmp++;
    if (!seen || dmem_req !== 1'b1 || pc_before !== 7'd2) begin
      n_bad++; $display("FAIL mem_hold got seen=%0d req=%0d pc=%0d want 1,1,2",
                        seen, dmem_req, pc_before);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (dmem_req !== 1'b0 || pc !== 7'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mem got req=%0d pc=%0d busy=%0d want 0,0,0",
                        dmem_req, pc, busy);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_bad++; $display("FAIL rst_instret got %0d want 0", instret);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_idle got busy=%0d req=%0d want 0,0",
                        busy, dmem_req);
    end
  endtask

  task automatic test_halt();
    int cyc, rfw, rfw_c, req, ack_c, moved;
    bit we, done;
    flags = C_SYSTEM;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (!done || halted !== 1'b1 || illegal !== 1'b0 || rfw !== 0) begin
      n_bad++; $display("FAIL ebreak got h=%0d i=%0d rfw=%0d want 1,0,0",
                        halted, illegal, rfw);
    end
    flags = C_ADDI;
    run = 1'b1;
    moved = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      step = c[0];
      if (busy || imem_re || pc !== 7'd0 || !halted) moved++;
    end
    run = 1'b0; step = 1'b0;
    n_cmp++;
    if (moved !== 0) begin
      n_bad++; $display("FAIL halt_hold got %0d active cycles want 0", moved);
    end
    do_reset();
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_clear got %0d want 0", halted);
    end
    flags = 10'h000;
    run_one(0, cyc, rfw, rfw_c, req, we, ack_c, done);
    n_cmp++;
    if (!done || halted !== 1'b1 || illegal !== 1'b1) begin
      n_bad++; $display("FAIL illegal got h=%0d i=%0d want 1,1",
                        halted, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_run_addi();
    test_step();
    test_jumps();
    test_wrap();
    test_mem();
    test_reset_in_mem();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
